button_debounce_repeat: RTL
===========================

// Module: button_debounce_repeat
// PURPOSE
//  Front-end conditioner for the counter's count-enable input. Synchronises a raw,
//  bouncing push-button and debounces it. Emits a one-cycle count pulse per
//  accepted press, plus optional auto-repeat pulses while the button is held.
//  pulse_o drives the downstream counter's enable; level_o gives the clean level.
// PARAMETERS
//  SYNC_STAGES     2    synchroniser flops on btn_in (>=2)
//  DEBOUNCE_CYCLES 16   consecutive equal samples needed to accept a change (>=1)
//  REPEAT_DELAY    256  cycles from press pulse to first repeat pulse (>=1)
//  REPEAT_PERIOD   64   cycles between successive repeat pulses (>=1)
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  reset, asynchronous, active-low
//  btn_in     in   1  raw button, asynchronous to clk, active-high
//  repeat_en  in   1  1 = auto-repeat enabled while held (synchronous level)
//  pulse_o    out  1  one-cycle count-enable pulse (press or repeat)
//  level_o    out  1  debounced button level
//  held_o     out  1  1 while in auto-repeat phase (first repeat already emitted)
// BEHAVIOUR
//  Reset: sync flops, counters, pulse_o, level_o, held_o all 0; FSM -> IDLE.
//   Reset overrides any state mid-operation; no pulse is generated by reset or its release.
//  Sync: btn_s = last of SYNC_STAGES flops; btn_s lags btn_in by SYNC_STAGES edges.
//  All outputs are registered. pulse_o is never high for 2 consecutive cycles from one event.
//  FSM (db_cnt counts consecutive btn_s samples; saturating, never wraps):
//   IDLE       level_o=0. btn_s=1 -> DB_PRESS, db_cnt=1.
//   DB_PRESS   btn_s=0 -> IDLE (bounce rejected, no output).
//              btn_s=1 and db_cnt reaches DEBOUNCE_CYCLES -> PRESSED.
//              On that transition: level_o<=1, pulse_o<=1, hold_cnt<=0.
//   PRESSED    btn_s=0 -> DB_RELEASE, db_cnt=1; hold_cnt frozen.
//              Otherwise, while repeat_en=1, hold_cnt increments each cycle:
//               - hold_cnt hits REPEAT_DELAY: pulse_o=1, held_o<=1.
//               - then pulse_o=1 every REPEAT_PERIOD cycles.
//   DB_RELEASE btn_s=1 -> PRESSED. Glitch: no pulse, level_o stays 1, hold_cnt resumes.
//              btn_s=0 and db_cnt reaches DEBOUNCE_CYCLES -> IDLE.
//              On that transition: level_o<=0, held_o<=0, no pulse.
//  Net press latency: pulse_o/level_o rise at edge SYNC_STAGES+DEBOUNCE_CYCLES
//   after btn_in rises and stays high. Release latency on level_o is the same.
//  Repeat timing: first repeat REPEAT_DELAY cycles after the press pulse. Later repeats
//   every REPEAT_PERIOD cycles. Cycles spent in DB_RELEASE do not count.
//  repeat_en=0 in PRESSED: hold_cnt<=0 and held_o<=0 next edge; no repeat pulses.
//   Re-asserting repeat_en restarts the full REPEAT_DELAY.
//  Simultaneous: a repeat pulse due in the cycle btn_s drops is still emitted;
//   btn_s change wins over the state transition.
//  Counter widths: $clog2 of the largest value +1; compares are exact equality.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Clean press, repeat_en=0: btn_in 0->1 held 30 cycles -> one pulse_o at edge 6, level_o=1
//   from edge 6; release -> level_o=0 6 edges later, no pulse.
//  Bounce: btn_in high 3 cycles then low -> pulse_o never high, level_o stays 0.
//  Auto-repeat, repeat_en=1, hold 25 cycles past press pulse P -> pulses at P, P+10, P+13,
//   P+16, ...; held_o=1 from P+10.
//  Release glitch: while pressed, btn_in low 2 cycles -> level_o stays 1, no extra pulse;
//   repeat schedule shifted by 2+ cycles only.
//  Reset mid-hold (held_o=1): rst_n low -> all outputs 0 immediately. Release with btn_in
//   still high -> exactly one press pulse 6 edges later.
//  repeat_en 1->0 during repeat -> held_o=0 next edge, no further pulses; 1 again ->
//   next pulse 10 cycles later.

Source files
------------

// File: rtl/button_debounce_repeat.sv
// Push-button conditioner: synchronises and debounces a raw button, then emits one
// count pulse per accepted press plus optional auto-repeat pulses while it is held.
module button_debounce_repeat #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 256,
    parameter int unsigned REPEAT_PERIOD   = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse_o,
    output logic level_o,
    output logic held_o
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_MAX = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX) + 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED    = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    logic [1:0]        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d, db_inc;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc, hold_wrap;
    logic              pulse_d, level_d, held_d;
    logic              rep_due;
    logic              db_done;

    // Metastability synchroniser on the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    assign db_inc    = db_cnt_q + DB_W'(1);
    assign db_done   = (db_inc == DB_W'(DEBOUNCE_CYCLES));
    assign hold_inc  = hold_cnt_q + HOLD_W'(1);
    // After the first repeat the counter folds back to REPEAT_DELAY, so it never exceeds HOLD_MAX
    assign hold_wrap = (hold_inc == HOLD_W'(HOLD_MAX)) ? HOLD_W'(REPEAT_DELAY) : hold_inc;
    assign rep_due   = repeat_en && ((hold_inc == HOLD_W'(REPEAT_DELAY)) ||
                                     (hold_inc == HOLD_W'(HOLD_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            pulse_o    <= 1'b0;
            level_o    <= 1'b0;
            held_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            pulse_o    <= pulse_d;
            level_o    <= level_d;
            held_o     <= held_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        pulse_d    = 1'b0;
        level_d    = level_q_hold();
        held_d     = held_o;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                held_d  = 1'b0;
                if (btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = PRESSED;
                        level_d    = 1'b1;
                        pulse_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        state_d  = DB_PRESS;
                        db_cnt_d = DB_W'(1);
                    end
                end
            end

            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_done) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    pulse_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    // A repeat falling due on the release sample is still honoured
                    if (rep_due) begin
                        pulse_d    = 1'b1;
                        held_d     = 1'b1;
                        hold_cnt_d = hold_wrap;
                    end
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        held_d  = 1'b0;
                    end else begin
                        state_d  = DB_RELEASE;
                        db_cnt_d = DB_W'(1);
                    end
                end else if (!repeat_en) begin
                    hold_cnt_d = '0;
                    held_d     = 1'b0;
                end else begin
                    hold_cnt_d = hold_wrap;
                    if (rep_due) begin
                        pulse_d = 1'b1;
                        held_d  = 1'b1;
                    end
                end
            end

            DB_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (db_done) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    held_d  = 1'b0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            default: begin
                state_d = IDLE;
                level_d = 1'b0;
                held_d  = 1'b0;
            end
        endcase
    end

    function automatic logic level_q_hold();
        return level_o;
    endfunction

endmodule
